// File: rtl/icache_miss_ctrl.sv
// Instruction-cache miss controller: stalls fetch, refills one line from local store, writes data and tag, then replays.
// Optional build macro ICACHE_CRIT_FIRST_EN: fetch the critical quadword first and wrap around the line.
module icache_miss_ctrl #(
    parameter int LINE_QW = 4,
    parameter int AW      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmiss,
    input  logic [AW-1:0]              miss_pc,
    input  logic                       flush,
    output logic                       ls_req,
    output logic [AW-1:0]              ls_addr,
    input  logic                       ls_gnt,
    input  logic                       ls_rvalid,
    input  logic [127:0]               ls_rdata,
    output logic                       ic_wr_en,
    output logic [$clog2(LINE_QW)-1:0] ic_wr_idx,
    output logic [127:0]               ic_wr_data,
    output logic                       ic_tag_wr,
    output logic [AW-1:0]              ic_line_addr,
    output logic                       stall,
    output logic                       replay,
    output logic [AW-1:0]              replay_pc
);

    localparam int QW_W  = $clog2(LINE_QW);
    localparam int CNT_W = QW_W + 1;
    localparam int OFF_W = QW_W + 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REQ    = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_REPLAY = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_QW - 1);

    // Quadword position within the line for the n-th transfer, rotated by the start quadword.
    function automatic logic [QW_W-1:0] qw_f(input logic [QW_W-1:0] base, input logic [QW_W-1:0] n);
        return base + n;
    endfunction

    logic [2:0]          state_r, state_nxt_s;
    logic [CNT_W-1:0]    req_cnt_r, req_cnt_nxt_s;
    logic [CNT_W-1:0]    rsp_cnt_r, rsp_cnt_nxt_s;
    logic [AW-OFF_W-1:0] line_hi_r;
    logic [AW-1:0]       pc_r;
    logic [QW_W-1:0]     crit_s;
    logic                accept_s, active_s, drain_s;
    logic                gnt_fire_s, rsp_fire_s, last_rsp_s, last_req_s, drained_s;
    logic [CNT_W-1:0]    rsp_after_s;

`ifdef ICACHE_CRIT_FIRST_EN
    logic [QW_W-1:0]     crit_r;

    // Critical quadword of the missing fetch group, captured on miss accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crit_r <= {QW_W{1'b0}};
        end else if (accept_s) begin
            crit_r <= miss_pc[OFF_W-1:4];
        end
    end

    assign crit_s = crit_r;
`else
    assign crit_s = {QW_W{1'b0}};
`endif

    assign accept_s    = (state_r == ST_IDLE) && cmiss && !flush;
    assign active_s    = (state_r == ST_REQ) || (state_r == ST_WAIT);
    assign drain_s     = (state_r == ST_DRAIN);
    assign gnt_fire_s  = ls_req && ls_gnt;
    assign rsp_fire_s  = ls_rvalid && (active_s || drain_s);
    assign last_rsp_s  = (rsp_cnt_r == CNT_LAST);
    assign last_req_s  = (req_cnt_r == CNT_LAST);
    assign rsp_after_s = rsp_fire_s ? (rsp_cnt_r + CNT_ONE) : rsp_cnt_r;
    // A grant is never counted in a flush cycle, so req_cnt_r is already final here.
    assign drained_s   = (rsp_after_s == req_cnt_r);

    // Next-state and counter update logic.
    always_comb begin
        state_nxt_s   = state_r;
        req_cnt_nxt_s = req_cnt_r;
        rsp_cnt_nxt_s = rsp_after_s;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s   = ST_REQ;
                    req_cnt_nxt_s = CNT_ZERO;
                    rsp_cnt_nxt_s = CNT_ZERO;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_REQ, ST_WAIT: begin
                if (gnt_fire_s) begin
                    req_cnt_nxt_s = req_cnt_r + CNT_ONE;
                end else begin
                    req_cnt_nxt_s = req_cnt_r;
                end
                if (flush) begin
                    state_nxt_s = drained_s ? ST_IDLE : ST_DRAIN;
                end else if (rsp_fire_s && last_rsp_s) begin
                    state_nxt_s = ST_REPLAY;
                end else if (gnt_fire_s && last_req_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_REPLAY: begin
                state_nxt_s = ST_IDLE;
            end
            ST_DRAIN: begin
                if (drained_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                req_cnt_nxt_s = CNT_ZERO;
                rsp_cnt_nxt_s = CNT_ZERO;
            end
        endcase
    end

    // State and transfer counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            req_cnt_r <= CNT_ZERO;
            rsp_cnt_r <= CNT_ZERO;
        end else begin
            state_r   <= state_nxt_s;
            req_cnt_r <= req_cnt_nxt_s;
            rsp_cnt_r <= rsp_cnt_nxt_s;
        end
    end

    // Miss PC and line address, held until the next accepted miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_hi_r <= {(AW-OFF_W){1'b0}};
            pc_r      <= {AW{1'b0}};
        end else if (accept_s) begin
            line_hi_r <= miss_pc[AW-1:OFF_W];
            pc_r      <= miss_pc;
        end
    end

    assign stall        = (state_r != ST_IDLE);
    assign ls_req       = (state_r == ST_REQ) && !flush;
    assign ls_addr      = {line_hi_r, qw_f(crit_s, req_cnt_r[QW_W-1:0]), 4'b0000};
    // Writes in a flush cycle are dropped as well so a cancelled line is never partially touched afterwards.
    assign ic_wr_en     = ls_rvalid && active_s && !flush;
    assign ic_wr_idx    = qw_f(crit_s, rsp_cnt_r[QW_W-1:0]);
    assign ic_wr_data   = ls_rdata;
    assign ic_tag_wr    = ic_wr_en && last_rsp_s;
    assign ic_line_addr = {line_hi_r, {OFF_W{1'b0}}};
    assign replay       = (state_r == ST_REPLAY) && !flush;
    assign replay_pc    = pc_r;

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Directed bench for icache_miss_ctrl with an in-order LS model and address/write scoreboards.
module tb_icache_miss_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmiss;
    logic [31:0]  miss_pc;
    logic         flush;
    logic         ls_req;
    logic [31:0]  ls_addr;
    logic         ls_gnt;
    logic         ls_rvalid;
    logic [127:0] ls_rdata;
    logic         ic_wr_en;
    logic [1:0]   ic_wr_idx;
    logic [127:0] ic_wr_data;
    logic         ic_tag_wr;
    logic [31:0]  ic_line_addr;
    logic         stall;
    logic         replay;
    logic [31:0]  replay_pc;

    icache_miss_ctrl #(.LINE_QW(4), .AW(32)) dut (
        .clk(clk), .rst(rst), .cmiss(cmiss), .miss_pc(miss_pc), .flush(flush),
        .ls_req(ls_req), .ls_addr(ls_addr), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
        .ls_rdata(ls_rdata), .ic_wr_en(ic_wr_en), .ic_wr_idx(ic_wr_idx),
        .ic_wr_data(ic_wr_data), .ic_tag_wr(ic_tag_wr), .ic_line_addr(ic_line_addr),
        .stall(stall), .replay(replay), .replay_pc(replay_pc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int lat = 2;
    int mc;
    int due_q[$];
    logic [127:0] rdat_q[$];
    logic [31:0]  exp_addr_q[$];
    logic [1:0]   exp_idx_q[$];
    logic [127:0] exp_dat_q[$];
    int n_stall, n_wr, n_tag, n_replay, n_gnt, tag_cyc, replay_cyc;
    logic [31:0] last_rpc, smp_addr, hold_a;
    logic smp_stall, smp_req;

    function automatic logic [127:0] dfun(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5a5a_a5a5, a + 32'h0000_1111};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("%s check did not match", tag);
        end
    endtask

    task automatic clr();
        n_stall = 0; n_wr = 0; n_tag = 0; n_replay = 0; n_gnt = 0;
        tag_cyc = -100; replay_cyc = -200; last_rpc = 32'h0;
    endtask

    // Expected request order: from the critical quadword (crit build) or quadword 0, wrapping in the line.
    task automatic push_miss(input logic [31:0] pc);
        logic [31:0] line;
        logic [1:0]  crit;
        logic [1:0]  qi;
        line = {pc[31:6], 6'b000000};
`ifdef ICACHE_CRIT_FIRST_EN
        crit = pc[5:4];
`else
        crit = 2'd0;
`endif
        for (int n = 0; n < 4; n++) begin
            qi = crit + 2'(n);
            exp_addr_q.push_back(line | {26'd0, qi, 4'b0000});
        end
    endtask

    task automatic step(input logic cm, input logic fl, input logic gn);
        logic [31:0]  a;
        logic [1:0]   ei;
        logic [127:0] ed;
        int d;
        cmiss  = cm;
        flush  = fl;
        ls_gnt = gn;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            ls_rvalid = 1'b1;
            ls_rdata  = rdat_q[0];
            void'(due_q.pop_front());
            void'(rdat_q.pop_front());
        end else begin
            ls_rvalid = 1'b0;
            ls_rdata  = 128'h0;
        end
        @(negedge clk);
        smp_stall = stall;
        smp_req   = ls_req;
        smp_addr  = ls_addr;
        if (ls_req && ls_gnt) begin
            n_gnt++;
            chk("addr_align", ls_addr[3:0], 4'h0);
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_grant", ls_req & ls_gnt, 1'b0);
            end else begin
                a = exp_addr_q.pop_front();
                chk("ls_addr", ls_addr, a);
                exp_idx_q.push_back(a[5:4]);
                exp_dat_q.push_back(dfun(a));
            end
            d = cyc + lat;
            if (due_q.size() > 0 && due_q[$] >= d) d = due_q[$] + 1;
            due_q.push_back(d);
            rdat_q.push_back(dfun(ls_addr));
        end
        if (ic_wr_en) begin
            n_wr++;
            if (exp_idx_q.size() == 0) begin
                chk("unexpected_write", ic_wr_en, 1'b0);
            end else begin
                ei = exp_idx_q.pop_front();
                ed = exp_dat_q.pop_front();
                chk("wr_idx", ic_wr_idx, ei);
                chk("wr_data", ic_wr_data, ed);
            end
        end
        if (stall) n_stall++;
        if (ic_tag_wr) begin n_tag++; tag_cyc = cyc; end
        if (replay) begin n_replay++; replay_cyc = cyc; last_rpc = replay_pc; end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_stall"}, stall, 1'b0);
        chk({pfx, "_ls_req"}, ls_req, 1'b0);
        chk({pfx, "_ls_addr"}, ls_addr, 32'h0);
        chk({pfx, "_wr_en"}, ic_wr_en, 1'b0);
        chk({pfx, "_wr_idx"}, ic_wr_idx, 2'd0);
        chk({pfx, "_tag_wr"}, ic_tag_wr, 1'b0);
        chk({pfx, "_line_addr"}, ic_line_addr, 32'h0);
        chk({pfx, "_replay"}, replay, 1'b0);
        chk({pfx, "_replay_pc"}, replay_pc, 32'h0);
    endtask

    initial begin
        rst = 1'b0; cmiss = 1'b0; flush = 1'b0; ls_gnt = 1'b0;
        ls_rvalid = 1'b0; ls_rdata = 128'h0; miss_pc = 32'h0;
        clr();
        #1;
        chk_reset_outputs("rst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic miss, grant held high, responses two cycles after each grant.
        clr(); lat = 2; miss_pc = 32'h0000_1234; push_miss(miss_pc);
        mc = cyc;
        step(1'b1, 1'b0, 1'b1);
        chk("stall_rise", stall, 1'b1);
        chk("line_addr", ic_line_addr, 32'h0000_1200);
        repeat (12) step(1'b0, 1'b0, 1'b1);
        chk("basic_stall_cycles", n_stall, 7);
        chk("basic_penalty", replay_cyc - mc, 7);
        chk("basic_tag_before_replay", tag_cyc, replay_cyc - 1);
        chk("basic_writes", n_wr, 4);
        chk("basic_tag_count", n_tag, 1);
        chk("basic_replay_count", n_replay, 1);
        chk("basic_replay_pc", last_rpc, 32'h0000_1234);
        chk("basic_addr_left", exp_addr_q.size(), 0);
        chk("basic_wr_left", exp_idx_q.size(), 0);
        chk("basic_idle", smp_stall, 1'b0);

        // Arbiter backpressure after the second grant.
        clr(); push_miss(miss_pc);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i == 2) hold_a = exp_addr_q[0];
            step(1'b0, 1'b0, (i < 2 || i >= 7));
            if (i >= 2 && i < 7) begin
                chk("bp_req", smp_req, 1'b1);
                chk("bp_addr_hold", smp_addr, hold_a);
            end
        end
        chk("bp_grants", n_gnt, 4);
        chk("bp_writes", n_wr, 4);
        chk("bp_replay", n_replay, 1);

        // Flush with three grants issued and one response back: two responses drain silently.
        clr(); push_miss(miss_pc);
        step(1'b1, 1'b0, 1'b0);
        lat = 2; step(1'b0, 1'b0, 1'b1);
        lat = 4; step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        exp_addr_q.delete(); exp_idx_q.delete(); exp_dat_q.delete();
        step(1'b0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        chk("drain_stall_last_rsp", smp_stall, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("drain_idle_after", smp_stall, 1'b0);
        chk("drain_writes", n_wr, 1);
        chk("drain_tag", n_tag, 0);
        chk("drain_replay", n_replay, 0);
        chk("drain_grants", n_gnt, 3);
        chk("drain_rsp_left", due_q.size(), 0);
        lat = 2;

        // cmiss together with flush in IDLE takes no miss.
        clr();
        step(1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        chk("cmiss_flush_stall", n_stall, 0);
        chk("cmiss_flush_grants", n_gnt, 0);

        // cmiss held high while busy is ignored.
        clr(); miss_pc = 32'h0000_1234; push_miss(miss_pc);
        step(1'b1, 1'b0, 1'b1);
        miss_pc = 32'h0000_5670;
        repeat (7) step(1'b1, 1'b0, 1'b1);
        chk("busy_cmiss_line", ic_line_addr, 32'h0000_1200);
        repeat (5) step(1'b0, 1'b0, 1'b1);
        chk("busy_cmiss_stall", n_stall, 7);
        chk("busy_cmiss_replay", n_replay, 1);
        chk("busy_cmiss_pc", last_rpc, 32'h0000_1234);
        chk("busy_cmiss_grants", n_gnt, 4);

        // Flush in REPLAY: tag written, replay suppressed.
        clr(); miss_pc = 32'h0000_1234; push_miss(miss_pc);
        step(1'b1, 1'b0, 1'b1);
        repeat (6) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1);
        chk("replay_flush_tag", n_tag, 1);
        chk("replay_flush_replay", n_replay, 0);
        chk("replay_flush_stall", n_stall, 7);
        chk("replay_flush_writes", n_wr, 4);

        // Asynchronous reset in the middle of REQ.
        clr(); push_miss(miss_pc);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        ls_rvalid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk_reset_outputs("arst");
        due_q.delete(); rdat_q.delete();
        exp_addr_q.delete(); exp_idx_q.delete(); exp_dat_q.delete();
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        clr(); miss_pc = 32'h0000_2468; push_miss(miss_pc);
        mc = cyc;
        step(1'b1, 1'b0, 1'b1);
        repeat (12) step(1'b0, 1'b0, 1'b1);
        chk("post_rst_stall", n_stall, 7);
        chk("post_rst_penalty", replay_cyc - mc, 7);
        chk("post_rst_writes", n_wr, 4);
        chk("post_rst_replay", n_replay, 1);
        chk("post_rst_pc", last_rpc, 32'h0000_2468);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
